string_loader: RTL and testbench

Upstream feeder for the string hardware accelerator. Takes one command plus a NUL-terminated byte stream per operand and packs the bytes into 32-bit words. It drives the accelerator's Avalon-MM slave port as a master: writes operand words, sets go, polls done, reads the result, then clears go. The result is returned on a valid/ready result port. Sits between the Nios II-side byte/command source and the accelerator.

---
 rtl/string_hw_pkg.sv | 33 +++
 rtl/string_word_packer.sv | 40 ++++
 rtl/string_loader.sv | 213 +++++++++++++++++++++
 tb/tb_string_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/string_hw_pkg.sv
// rtl/string_hw_pkg.sv - shared constants, types and helpers for the string accelerator feeder
package string_hw_pkg;

  localparam int MAX_WORDS_DEF = 8;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_A_BASE = 5'd1;
  localparam logic [4:0] ADDR_B_BASE = 5'd9;
  localparam logic [4:0] ADDR_RESULT = 5'd17;

  localparam int CTRL_DONE    = 0;
  localparam int CTRL_GO      = 1;
  localparam int CTRL_IDX_LSB = 2;

  typedef enum logic [2:0] {
    FN_COMPARE  = 3'd0,
    FN_TO_UPPER = 3'd1,
    FN_TO_LOWER = 3'd2
  } fn_index_e;

  typedef enum logic [3:0] {
    IDLE, PACK, WR_WORD, ZFILL, GO, POLL_RD, POLL_WT, RES_RD, RES_WT, RES_OUT, CLR_GO
  } state_e;

  function automatic logic [31:0] ctrl_word(input fn_index_e idx, input logic go);
    logic [31:0] w;
    w = '0;
    w[CTRL_IDX_LSB +: 3] = idx;
    w[CTRL_GO] = go;
    return w;
  endfunction

endpackage

// File: rtl/string_word_packer.sv
// rtl/string_word_packer.sv - packs bytes MSB-first into a 32-bit word with byte count and full flag
module string_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic [2:0]  count,
  output logic        full
);

  // word_nxt lets the caller write a completed word in the same cycle its last byte arrives
  always_comb begin
    word_nxt = word;
    case (count[1:0])
      2'd0:    word_nxt[31:24] = data;
      2'd1:    word_nxt[23:16] = data;
      2'd2:    word_nxt[15:8]  = data;
      default: word_nxt[7:0]   = data;
    endcase
  end

  assign full = load && (count == 3'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= word_nxt;
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/string_loader.sv
// rtl/string_loader.sv - byte-stream to Avalon-MM feeder for the string accelerator
// STRING_LOADER_TIMEOUT_EN enables the poll timeout counter.
module string_loader
  import string_hw_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
`ifdef STRING_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_index,
  input  logic        cmd_two_op,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [4:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  localparam int PW = $clog2(MAX_WORDS + 2);
  localparam logic [PW-1:0] PTR_END = PW'(MAX_WORDS);

  state_e        state;
  fn_index_e     index;
  logic          two_op, op_b, nul_seen;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [4:0]    op_addr, op_addr_nxt;
  logic [31:0]   pk_word, pk_word_nxt;
  logic [2:0]    pk_count;
  logic          pk_full, pk_load, pk_clear, s_fire, room;

`ifdef STRING_LOADER_TIMEOUT_EN
  localparam int PCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [PCW-1:0] poll_cnt;
`endif

  assign ptr_nxt     = ptr + PW'(1);
  assign op_addr     = (op_b ? ADDR_B_BASE : ADDR_A_BASE) + 5'(ptr);
  assign op_addr_nxt = (op_b ? ADDR_B_BASE : ADDR_A_BASE) + 5'(ptr_nxt);
  assign s_fire      = (state == PACK) && s_valid && s_ready;
  assign room        = ptr < PTR_END;
  assign pk_load     = s_fire && (s_data != 8'h00) && room;
  assign pk_clear    = (state == IDLE) || (state == WR_WORD);

  string_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .load     (pk_load),
    .data     (s_data),
    .word     (pk_word),
    .word_nxt (pk_word_nxt),
    .count    (pk_count),
    .full     (pk_full)
  );

  // Bus strobes are set on entry to the state that owns the access, so they are visible during it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      index        <= FN_COMPARE;
      two_op       <= 1'b0;
      op_b         <= 1'b0;
      nul_seen     <= 1'b0;
      ptr          <= '0;
      cmd_ready    <= 1'b0;
      s_ready      <= 1'b0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_err      <= 1'b0;
`ifdef STRING_LOADER_TIMEOUT_EN
      poll_cnt     <= '0;
`endif
    end else begin
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            index     <= fn_index_e'(cmd_index);
            two_op    <= cmd_two_op;
            res_err   <= 1'b0;
            op_b      <= 1'b0;
            nul_seen  <= 1'b0;
            ptr       <= '0;
            s_ready   <= 1'b1;
            state     <= PACK;
          end
        end
        PACK: if (s_fire) begin
          if (s_data != 8'h00) begin
            if (!room) begin
              res_err <= 1'b1;
            end else if (pk_full) begin
              s_ready <= 1'b0; nul_seen <= 1'b0;
              m_chipselect <= 1'b1; m_write <= 1'b1;
              m_address <= op_addr; m_writedata <= pk_word_nxt;
              state <= WR_WORD;
            end
          end else if (pk_count != 3'd0) begin
            s_ready <= 1'b0; nul_seen <= 1'b1;
            m_chipselect <= 1'b1; m_write <= 1'b1;
            m_address <= op_addr; m_writedata <= pk_word;
            state <= WR_WORD;
          end else begin
            s_ready <= 1'b0;
            if (room) begin
              m_chipselect <= 1'b1; m_write <= 1'b1;
              m_address <= op_addr; m_writedata <= '0;
            end
            state <= ZFILL;
          end
        end
        WR_WORD: begin
          ptr <= ptr_nxt;
          if (nul_seen) begin
            if (ptr_nxt < PTR_END) begin
              m_chipselect <= 1'b1; m_write <= 1'b1;
              m_address <= op_addr_nxt; m_writedata <= '0;
            end
            state <= ZFILL;
          end else begin
            s_ready <= 1'b1;
            state   <= PACK;
          end
        end
        // ptr names the word written this cycle; ptr == MAX_WORDS means nothing is left to clear
        ZFILL: begin
          if (ptr_nxt < PTR_END) begin
            ptr <= ptr_nxt;
            m_chipselect <= 1'b1; m_write <= 1'b1;
            m_address <= op_addr_nxt; m_writedata <= '0;
          end else if (two_op && !op_b) begin
            op_b <= 1'b1; ptr <= '0; nul_seen <= 1'b0;
            s_ready <= 1'b1;
            state <= PACK;
          end else begin
            m_chipselect <= 1'b1; m_write <= 1'b1;
            m_address <= ADDR_CTRL; m_writedata <= ctrl_word(index, 1'b1);
`ifdef STRING_LOADER_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state <= GO;
          end
        end
        GO: begin
          m_chipselect <= 1'b1; m_read <= 1'b1; m_address <= ADDR_CTRL;
          state <= POLL_RD;
        end
        POLL_RD: state <= POLL_WT;
        POLL_WT: begin
          if (m_readdata[CTRL_DONE]) begin
            m_chipselect <= 1'b1; m_read <= 1'b1; m_address <= ADDR_RESULT;
            state <= RES_RD;
          end
`ifdef STRING_LOADER_TIMEOUT_EN
          else if (poll_cnt == PCW'(TIMEOUT_CYCLES - 1)) begin
            res_data <= '0; res_err <= 1'b1; res_valid <= 1'b1;
            state <= RES_OUT;
          end else begin
            poll_cnt <= poll_cnt + PCW'(1);
            m_chipselect <= 1'b1; m_read <= 1'b1; m_address <= ADDR_CTRL;
            state <= POLL_RD;
          end
`else
          else begin
            m_chipselect <= 1'b1; m_read <= 1'b1; m_address <= ADDR_CTRL;
            state <= POLL_RD;
          end
`endif
        end
        RES_RD: state <= RES_WT;
        RES_WT: begin
          res_data  <= m_readdata;
          res_valid <= 1'b1;
          state     <= RES_OUT;
        end
        RES_OUT: if (res_ready) begin
          res_valid <= 1'b0;
          m_chipselect <= 1'b1; m_write <= 1'b1;
          m_address <= ADDR_CTRL; m_writedata <= ctrl_word(index, 1'b0);
          state <= CLR_GO;
        end
        CLR_GO: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_string_loader.sv
// tb/tb_string_loader.sv - table-driven scoreboard bench for string_loader with an accelerator slave model
module tb_string_loader;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_two_op;
  logic [2:0]  cmd_index;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        m_chipselect, m_write, m_read;
  logic [4:0]  m_address;
  logic [31:0] m_writedata, m_readdata;
  logic        res_valid, res_ready, res_err;
  logic [31:0] res_data;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [31:0] d; logic e; } res_t;
  typedef struct {
    logic [2:0]  idx;
    logic        two;
    string       a;
    string       b;
    int          done_after;
    logic [31:0] result;
    logic        timeout;
    logic        stall;
  } rec_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  rec_t tbl[$];

  int          total = 0;
  int          bad = 0;
  int          polls = 0;
  int          done_after = 1;
  logic [31:0] slave_result = '0;
  logic [31:0] ctrl_reg = '0;
  bit          mon_en = 1'b1;

  string_loader #(
    .MAX_WORDS(MAXW)
`ifdef STRING_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_two_op(cmd_two_op),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_read(m_read),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Accelerator slave: read data appears for the cycle after the read strobe.
  always @(posedge clk) begin
    m_readdata <= '0;
    if (m_chipselect && m_write && m_address == 5'd0) begin
      ctrl_reg <= m_writedata;
      if (m_writedata[1]) polls <= 0;
    end
    if (m_chipselect && m_read) begin
      if (m_address == 5'd0) begin
        m_readdata <= {ctrl_reg[31:1], (polls + 1 >= done_after)};
        polls <= polls + 1;
      end else if (m_address == 5'd17) begin
        m_readdata <= slave_result;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && reset && m_chipselect && m_write) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", m_address, m_writedata);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        if (m_address !== w.a || m_writedata !== w.d) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", m_address, m_writedata, w.a, w.d);
        end
      end
    end
    if (mon_en && reset && res_valid && res_ready) begin
      total += 2;
      if (exp_res.size() == 0) begin
        bad += 2;
        $display("FAIL unexpected_result: data=%h err=%0b, required none", res_data, res_err);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        if (res_data !== r.d) begin
          bad++;
          $display("FAIL res_data: got %h, required %h", res_data, r.d);
        end
        if (res_err !== r.e) begin
          bad++;
          $display("FAIL res_err: got %0b, required %0b", res_err, r.e);
        end
      end
    end
  end

  function automatic rec_t mk(logic [2:0] idx, logic two, string a, string b, int da,
                              logic [31:0] result, logic timeout, logic stall);
    rec_t r;
    r.idx = idx; r.two = two; r.a = a; r.b = b; r.done_after = da;
    r.result = result; r.timeout = timeout; r.stall = stall;
    return r;
  endfunction

  function automatic logic [31:0] word_of(string s, int k);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      logic [7:0] c;
      c = (4 * k + j < s.len()) ? s[4 * k + j] : 8'h00;
      w = {w[23:0], c};
    end
    return w;
  endfunction

  function automatic logic [31:0] ctrl(logic [2:0] idx, logic go);
    return {27'd0, idx, go, 1'b0};
  endfunction

  task automatic push_operand(input string s, input logic [4:0] base);
    for (int k = 0; k < MAXW; k++) exp_wr.push_back({base + 5'(k), word_of(s, k)});
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic send_cmd(input logic [2:0] idx, input logic two);
    bit hs = 1'b0;
    cmd_valid = 1'b1; cmd_index = idx; cmd_two_op = two;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cmd_ready) begin hs = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit hs = 1'b0;
    s_valid = 1'b1; s_data = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_ready) begin hs = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 8'h00;
    if (!hs) begin
      total++; bad++;
      $display("FAIL byte_handshake: s_ready=0 after 200 cycles, required 1");
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h00);
  endtask

  task automatic run_rec(input rec_t r);
    logic ovf;
    bit ok = 1'b0;
    ovf = (r.a.len() > 4 * MAXW) || (r.two && r.b.len() > 4 * MAXW);
    push_operand(r.a, 5'd1);
    if (r.two) push_operand(r.b, 5'd9);
    exp_wr.push_back({5'd0, ctrl(r.idx, 1'b1)});
    exp_wr.push_back({5'd0, ctrl(r.idx, 1'b0)});
    exp_res.push_back({r.timeout ? 32'd0 : r.result, ovf || r.timeout});
    done_after = r.done_after;
    slave_result = r.result;
    res_ready = !r.stall;
    send_cmd(r.idx, r.two);
    send_str(r.a);
    if (r.two) send_str(r.b);
    if (r.stall) begin
      bit seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (res_valid) begin seen = 1'b1; break; end
      end
      check("stall_res_valid_rise", 64'(seen), 64'd1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("stall_res_valid_hold", 64'(res_valid), 64'd1);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (exp_wr.size() == 0 && exp_res.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL run_done: writes_left=%0d results_left=%0d cmd_ready=%0b, required 0 0 1",
               exp_wr.size(), exp_res.size(), cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({cmd_ready, s_ready, m_chipselect, m_write, m_read, m_address,
                m_writedata, res_valid, res_data != 32'd0, res_err});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_two_op = 1'b0;
    s_valid = 1'b0; s_data = '0; res_ready = 1'b1;

    tbl.push_back(mk(3'd1, 1'b0, "abcd", "", 1, 32'h41424344, 1'b0, 1'b0));
    tbl.push_back(mk(3'd0, 1'b1, "abcdefgh", "abcdefgh", 3, 32'h00000000, 1'b0, 1'b0));
    tbl.push_back(mk(3'd2, 1'b0, "Ab", "", 2, 32'h61620000, 1'b0, 1'b1));
    tbl.push_back(mk(3'd1, 1'b0, "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMN", "", 1, 32'h12345678, 1'b0, 1'b0));
    tbl.push_back(mk(3'd0, 1'b1, "", "xyz12", 2, 32'hffffffff, 1'b0, 1'b0));
    tbl.push_back(mk(3'd1, 1'b0, "hello world!", "", 1, 32'h48454c4c, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("cmd_ready_one_cycle_after", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < tbl.size(); i++) run_rec(tbl[i]);

`ifdef STRING_LOADER_TIMEOUT_EN
    run_rec(mk(3'd1, 1'b0, "abc", "", 1_000_000, 32'hdeadbeef, 1'b1, 1'b0));
    check("timeout_poll_count", 64'(polls), 64'd4);
`endif

    // Reset asserted while zero-filling operand A must clear every output at once.
    begin
      bit hit = 1'b0;
      mon_en = 1'b0;
      done_after = 1;
      send_cmd(3'd1, 1'b0);
      send_str("ab");
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (m_chipselect && m_write && m_address == 5'd3) begin hit = 1'b1; break; end
      end
      check("zfill_reached", 64'(hit), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset_outputs", outs(), 64'd0);
      exp_wr.delete();
      exp_res.delete();
      @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      run_rec(tbl[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
